// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IF and LSU. grant[0] = IF, grant[1] = LSU (one-hot).
// Default build: fixed LSU-over-IF priority.
// MEM_ARB_RR_EN defined: round-robin on ties using a last_owner register.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       if_valid,
    input  logic       lsu_valid,
    input  logic       handshake,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    // Remember who won the most recent handshake; IF after reset so LSU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_IF;
        end else if (handshake) begin
            last_owner <= grant[1] ? OWN_LSU : OWN_IF;
        end
    end

    // On a tie the requester that did not win last time is chosen; idle grant follows the same rule.
    always_comb begin
        grant = 2'b10;
        if (if_valid && lsu_valid) begin
            grant = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
        end else if (if_valid) begin
            grant = 2'b01;
        end else if (lsu_valid) begin
            grant = 2'b10;
        end else begin
            grant = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_grant_inputs;
    assign unused_grant_inputs = ^{clk, rst, handshake};

    // IF is only granted when LSU is not asking; with nobody asking LSU holds the grant.
    always_comb begin
        grant = 2'b10;
        if (if_valid && !lsu_valid) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF / LSU) front end for the single data-memory port.
// One transaction at a time: IDLE -> BUSY (LATENCY cycles) -> RESP -> IDLE.
// Exactly one mem_ce pulse per transaction, on the last BUSY cycle.
// Optional macro MEM_ARB_RR_EN selects round-robin grant instead of LSU-first.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_we,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    owner_t            owner_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0] grant;
    logic       if_hs, lsu_hs, handshake, last_busy;

    assign if_hs     = if_req_valid  && if_req_ready;
    assign lsu_hs    = lsu_req_valid && lsu_req_ready;
    assign handshake = if_hs || lsu_hs;
    assign last_busy = (state_q == S_BUSY) && (cnt_q == '0);

    mem_arb_grant u_grant (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_req_valid),
        .lsu_valid (lsu_req_valid),
        .handshake (handshake),
        .grant     (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept, count down the emulated latency, respond once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture request on handshake, run the latency counter, latch read data on the pulse cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner_q <= OWN_IF;
            rdata_q <= '0;
        end else begin
            if (handshake) begin
                cnt_q   <= CNT_LOAD;
                addr_q  <= lsu_hs ? lsu_req_addr : if_req_addr;
                we_q    <= lsu_hs && lsu_req_we;
                wdata_q <= lsu_hs ? lsu_req_wdata : '0;
                wmask_q <= lsu_hs ? lsu_req_wmask : '0;
                owner_q <= lsu_hs ? OWN_LSU : OWN_IF;
            end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (last_busy) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end
        end
    end

    // Outputs: readies only in IDLE (and never during reset), memory port in BUSY, response in RESP.
    always_comb begin
        if_req_ready   = 1'b0;
        lsu_req_ready  = 1'b0;
        if_resp_valid  = 1'b0;
        if_resp_data   = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        mem_addr       = '0;
        mem_ce         = 1'b0;
        mem_we         = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        case (state_q)
            S_IDLE: begin
                if_req_ready  = !rst && grant[0];
                lsu_req_ready = !rst && grant[1];
            end
            S_BUSY: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wmask = wmask_q;
                mem_ce    = (cnt_q == '0);
                mem_we    = (cnt_q == '0) && we_q;
            end
            S_RESP: begin
                if (owner_q == OWN_LSU) begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_data  = rdata_q;
                end else begin
                    if_resp_valid = 1'b1;
                    if_resp_data  = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small byte-masked memory model.
module tb_mem_arbiter;

    localparam int LAT = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_req_addr = '0;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [63:0] lsu_req_addr = '0;
    logic        lsu_req_we = 1'b0;
    logic [63:0] lsu_req_wdata = '0;
    logic [7:0]  lsu_req_wmask = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_data;
    logic [63:0] mem_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // Memory model: 256 words indexed by addr[10:3], combinational read, masked write on the pulse.
    logic [63:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[10:3]];
    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (mem_wmask[b]) mem[mem_addr[10:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit lsu; logic [63:0] data; } exp_t;
    exp_t expq[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor state observed on the falling edge.
    int          ce_cnt = 0, ce_cyc = -1, resp_cyc = -1, if_hs_cnt = 0, lsu_hs_cnt = 0;
    logic        ce_we;
    logic [7:0]  ce_mask;
    logic [63:0] ce_addr;

    // Monitor: pop expectations on each response pulse, record memory pulses and handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (if_req_valid && if_req_ready) if_hs_cnt++;
        if (lsu_req_valid && lsu_req_ready) lsu_hs_cnt++;
        if (mem_we && !mem_ce) chk("we_without_ce", 64'(mem_we), 64'(0));
        if (mem_ce) begin
            ce_cnt++;
            ce_cyc  = cyc;
            ce_we   = mem_we;
            ce_mask = mem_wmask;
            ce_addr = mem_addr;
            chk("ready_during_ce", 64'(if_req_ready | lsu_req_ready), 64'(0));
        end
        if (if_resp_valid || lsu_resp_valid) begin
            resp_cyc = cyc;
            chk("ready_during_resp", 64'(if_req_ready | lsu_req_ready), 64'(0));
            chk("resp_one_owner", 64'(if_resp_valid & lsu_resp_valid), 64'(0));
            if (expq.size() == 0) begin
                chk("resp_unexpected", 64'(1), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("resp_owner_lsu", 64'(lsu_resp_valid), 64'(e.lsu));
                chk("resp_data", lsu_resp_valid ? lsu_resp_data : if_resp_data, e.data);
            end
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("resp_timeout", 64'(expq.size()), 64'(0));
    endtask

    // One transaction with full timing checks around the handshake cycle T.
    task automatic do_req(input bit lsu, input logic [63:0] addr, input bit we,
                          input logic [63:0] wdata, input logic [7:0] wmask, input logic [63:0] exp);
        int t = -1;
        int ce0;
        exp_t e;
        @(posedge clk); #1;
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_we = we;
            lsu_req_wdata = wdata; lsu_req_wmask = wmask;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (lsu ? lsu_req_ready : if_req_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            $display("FAIL handshake_timeout lsu=%0d", lsu);
            $fatal(1, "no handshake");
        end
        ce0 = ce_cnt;
        e.lsu = lsu; e.data = exp;
        expq.push_back(e);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        wait_empty();
        chk("ce_count", 64'(ce_cnt - ce0), 64'(1));
        chk("ce_cycle", 64'(ce_cyc), 64'(t + LAT));
        chk("resp_cycle", 64'(resp_cyc), 64'(t + LAT + 1));
        chk("ce_we", 64'(ce_we), 64'(we));
        chk("ce_mask", 64'(ce_mask), lsu ? 64'(wmask) : 64'(0));
        chk("ce_addr", ce_addr, addr);
        @(negedge clk);
        chk("ready_after_resp", 64'(if_req_ready | lsu_req_ready), 64'(1));
    endtask

    initial begin
        int t, t_lsu, t_if, ce0, ifh0;
        exp_t e;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 64'h1122334455667788;
        mem[3] = 64'h1111111122222222;

        // Reset state: readies held low during reset even in IDLE.
        @(negedge clk); @(negedge clk);
        chk("rst_if_ready", 64'(if_req_ready), 64'(0));
        chk("rst_lsu_ready", 64'(lsu_req_ready), 64'(0));
        chk("rst_mem_ce", 64'(mem_ce), 64'(0));
        chk("rst_mem_addr", mem_addr, 64'(0));
        chk("rst_resp", 64'({if_resp_valid, lsu_resp_valid}), 64'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_lsu_ready", 64'(lsu_req_ready), 64'(1));
        chk("idle_if_ready", 64'(if_req_ready), 64'(0));

        // IF read, LSU write, readback, masked upper-half write and readback.
        do_req(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h1122334455667788);
        do_req(1'b1, 64'h8000_0010, 1'b1, 64'hDEADBEEF, 8'h0F, 64'h0);
        do_req(1'b1, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h00000000DEADBEEF);
        do_req(1'b1, 64'h8000_0018, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 8'hF0, 64'h0);
        do_req(1'b1, 64'h8000_0018, 1'b0, 64'h0, 8'h00, 64'hAAAAAAAA_22222222);

        // Reset during BUSY of a write aborts it: no pulse, no response.
        @(posedge clk); #1;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0020; lsu_req_we = 1'b1;
        lsu_req_wdata = 64'h55; lsu_req_wmask = 8'hFF;
        t = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (lsu_req_ready) begin t = cyc; break; end
        end
        chk("abort_handshake", 64'(t >= 0), 64'(1));
        ce0 = ce_cnt;
        @(posedge clk); #1; lsu_req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_ce", 64'(mem_ce), 64'(0));
        chk("post_rst_mem_addr", mem_addr, 64'(0));
        chk("post_rst_mem_wdata", mem_wdata, 64'(0));
        chk("post_rst_mem_wmask", 64'(mem_wmask), 64'(0));
        chk("post_rst_resp", 64'({if_resp_valid, lsu_resp_valid}), 64'(0));
        repeat (8) @(negedge clk);
        chk("abort_no_ce", 64'(ce_cnt - ce0), 64'(0));

        // Both valid continuously for four transaction slots.
        ifh0 = if_hs_cnt;
        for (int i = 0; i < 4; i++) begin
            e.lsu = !(RR && (i % 2 == 1));
            e.data = e.lsu ? 64'h0 : 64'h1122334455667788;
            expq.push_back(e);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0020; lsu_req_we = 1'b0;
        repeat (4 * (LAT + 2)) @(posedge clk);
        #1; if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        wait_empty();
        chk("tie_if_grants", 64'(if_hs_cnt - ifh0), RR ? 64'(2) : 64'(0));

        // IF held while LSU asks once: IF accepted on the first IDLE cycle after LSU.
        e.lsu = 1'b1; e.data = 64'h00000000DEADBEEF; expq.push_back(e);
        e.lsu = 1'b0; e.data = 64'h1122334455667788; expq.push_back(e);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
        lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0010; lsu_req_we = 1'b0;
        t_lsu = -1; t_if = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (lsu_req_ready) begin t_lsu = cyc; break; end
        end
        chk("hold_if_not_first", 64'(t_lsu >= 0), 64'(1));
        @(posedge clk); #1; lsu_req_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if_req_ready) begin t_if = cyc; break; end
        end
        chk("hold_if_accept_cycle", 64'(t_if), 64'(t_lsu + LAT + 2));
        @(posedge clk); #1; if_req_valid = 1'b0;
        wait_empty();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
